// File: rtl/next_addr_ctl.sv
// next_addr_ctl
//   Next-address control for a cascade of 4-bit microprogram sequencer
//   slices. Decodes the 4-bit next-address instruction together with the
//   condition test and the loop-counter state. From these it drives the slice
//   source select, force-zero, stack controls and the active-low branch-source
//   enables. It also holds the loop counter used by the repeat/loop
//   instructions.
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   instr     in   [3:0] next-address instruction (pipeline register)
//   ccen_n    in   condition enable; 1 forces the test to pass
//   cc        in   condition code; 1 = pass when enabled
//   load_val  in   [CW-1:0] counter load value (pipeline branch field)
//   s1, s0    out  slice source select: PC=00 AR=01 STK=10 D=11
//   zero      out  active-low force-zero to the slices
//   fe        out  active-low stack (file) enable
//   pup       out  1 = push, 0 = pop (valid when fe=0)
//   pl_n      out  active-low pipeline branch-field enable onto din
//   map_n     out  active-low mapping PROM enable onto din
//   vect_n    out  active-low vector enable onto din
//   cnt_zero  out  loop counter equals zero
//   count     out  [CW-1:0] loop counter value
module next_addr_ctl #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [3:0]    instr,
  input  logic          ccen_n,
  input  logic          cc,
  input  logic [CW-1:0] load_val,
  output logic          s1,
  output logic          s0,
  output logic          zero,
  output logic          fe,
  output logic          pup,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
  output logic          cnt_zero,
  output logic [CW-1:0] count
);

  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  typedef enum logic [3:0] {
    OP_JZ   = 4'h0,
    OP_CJS  = 4'h1,
    OP_JMAP = 4'h2,
    OP_CJP  = 4'h3,
    OP_PUSH = 4'h4,
    OP_JSRP = 4'h5,
    OP_CJV  = 4'h6,
    OP_JRP  = 4'h7,
    OP_RFCT = 4'h8,
    OP_RPCT = 4'h9,
    OP_CRTN = 4'hA,
    OP_CJPP = 4'hB,
    OP_LDCT = 4'hC,
    OP_LOOP = 4'hD,
    OP_CONT = 4'hE,
    OP_TWB  = 4'hF
  } op_t;

  logic [CW-1:0] count_q;
  logic          pass;
  logic          cz;
  logic [1:0]    sel;
  logic          ld;
  logic          dec;
  op_t           op;

  assign pass = ccen_n | cc;
  assign cz   = (count_q == '0);
  assign op   = op_t'(instr);

  // Stack-op helpers: push = fe0/pup1, pop = fe0/pup0, hold = fe1/pup0.
  always_comb begin
    sel    = SRC_PC;
    zero   = 1'b1;
    fe     = 1'b1;
    pup    = 1'b0;
    pl_n   = 1'b0;
    map_n  = 1'b1;
    vect_n = 1'b1;
    ld     = 1'b0;
    dec    = 1'b0;

    unique case (op)
      OP_JZ: zero = 1'b0;
      OP_CJS: begin
        if (pass) begin
          sel = SRC_D;
          fe  = 1'b0;
          pup = 1'b1;
        end
      end
      OP_JMAP: begin
        sel   = SRC_D;
        pl_n  = 1'b1;
        map_n = 1'b0;
      end
      OP_CJP: begin
        if (pass) sel = SRC_D;
      end
      OP_PUSH: begin
        fe  = 1'b0;
        pup = 1'b1;
        ld  = pass;
      end
      OP_JSRP: begin
        sel = pass ? SRC_D : SRC_AR;
        fe  = 1'b0;
        pup = 1'b1;
      end
      OP_CJV: begin
        sel    = pass ? SRC_D : SRC_PC;
        pl_n   = 1'b1;
        vect_n = 1'b0;
      end
      OP_JRP: sel = pass ? SRC_D : SRC_AR;
      OP_RFCT: begin
        if (!cz) begin
          sel = SRC_STK;
          dec = 1'b1;
        end else begin
          fe = 1'b0;
        end
      end
      OP_RPCT: begin
        if (!cz) begin
          sel = SRC_D;
          dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          sel = SRC_STK;
          fe  = 1'b0;
        end
      end
      OP_CJPP: begin
        if (pass) begin
          sel = SRC_D;
          fe  = 1'b0;
        end
      end
      OP_LDCT: ld = 1'b1;
      OP_LOOP: begin
        if (pass) fe = 1'b0;
        else      sel = SRC_STK;
      end
      OP_CONT: ;
      OP_TWB: begin
        if (pass) begin
          fe = 1'b0;
        end else if (!cz) begin
          sel = SRC_STK;
          dec = 1'b1;
        end else begin
          sel = SRC_D;
          fe  = 1'b0;
        end
      end
      default: ;
    endcase

    // While in reset the slices must see address 0 with the stack idle,
    // independent of whatever the pipeline register holds.
    if (!reset_n) begin
      sel    = SRC_PC;
      zero   = 1'b0;
      fe     = 1'b1;
      pup    = 1'b0;
      pl_n   = 1'b0;
      map_n  = 1'b1;
      vect_n = 1'b1;
      ld     = 1'b0;
      dec    = 1'b0;
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

  // Decode never asserts dec when the count is zero, so no wrap guard here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count_q <= '0;
    else if (ld)   count_q <= load_val;
    else if (dec)  count_q <= count_q - CW'(1);
  end

  assign count    = count_q;
  assign cnt_zero = cz;

endmodule

// File: tb/tb_next_addr_ctl.sv
// tb_next_addr_ctl
//   Self-checking bench for next_addr_ctl: a vector table for every
//   opcode/condition/count case, plus hand sequences for reset, LDCT+RFCT
//   and reset during a loop. Expected records go through a scoreboard queue.
module tb_next_addr_ctl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] instr;
  logic       ccen_n;
  logic       cc;
  logic [7:0] load_val;
  logic       s1, s0, zero, fe, pup, pl_n, map_n, vect_n, cnt_zero;
  logic [7:0] count;

  int tests = 0;
  int fails = 0;

  next_addr_ctl #(.CW(8)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .ccen_n(ccen_n),
    .cc(cc), .load_val(load_val), .s1(s1), .s0(s0), .zero(zero), .fe(fe),
    .pup(pup), .pl_n(pl_n), .map_n(map_n), .vect_n(vect_n),
    .cnt_zero(cnt_zero), .count(count)
  );

  always #5 clock = ~clock;

  // {s1,s0,zero,fe,pup,pl_n,map_n,vect_n}
  logic [7:0] outs;
  assign outs = {s1, s0, zero, fe, pup, pl_n, map_n, vect_n};

  // Low six bits {zero,fe,pup,pl_n,map_n,vect_n}
  localparam logic [5:0] H   = 6'b110011;  // stack hold
  localparam logic [5:0] PU  = 6'b101011;  // push
  localparam logic [5:0] PO  = 6'b100011;  // pop
  localparam logic [5:0] JZH = 6'b010011;  // force zero, hold
  localparam logic [5:0] MAP = 6'b110101;  // mapping PROM on din
  localparam logic [5:0] VEC = 6'b110110;  // vector on din
  localparam logic [7:0] LV  = 8'hA5;      // load_val during table vectors

  typedef struct {
    logic [3:0] instr;
    logic       ccen_n;
    logic       cc;
    logic [7:0] pre;
    logic [7:0] o;
    logic [7:0] post;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] o;
    logic [7:0] post;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  function automatic vec_t mk(logic [3:0] i, logic cn, logic c,
                              logic [7:0] pre, logic [7:0] o, logic [7:0] post);
    vec_t v;
    v.instr = i; v.ccen_n = cn; v.cc = c; v.pre = pre; v.o = o; v.post = post;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    @(negedge clock);
    instr = 4'hC; ccen_n = 1'b0; cc = 1'b0; load_val = v;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- vector table ----------------
    vq.push_back(mk(4'h0, 0, 1, 8'd4, {2'b00, JZH}, 8'd4));
    vq.push_back(mk(4'h1, 0, 0, 8'd4, {2'b00, H},   8'd4));
    vq.push_back(mk(4'h1, 0, 1, 8'd4, {2'b11, PU},  8'd4));
    vq.push_back(mk(4'h1, 1, 0, 8'd4, {2'b11, PU},  8'd4));
    vq.push_back(mk(4'h2, 0, 0, 8'd4, {2'b11, MAP}, 8'd4));
    vq.push_back(mk(4'h3, 0, 0, 8'd4, {2'b00, H},   8'd4));
    vq.push_back(mk(4'h3, 0, 1, 8'd4, {2'b11, H},   8'd4));
    vq.push_back(mk(4'h4, 0, 0, 8'd4, {2'b00, PU},  8'd4));
    vq.push_back(mk(4'h4, 0, 1, 8'd4, {2'b00, PU},  LV));
    vq.push_back(mk(4'h5, 0, 0, 8'd4, {2'b01, PU},  8'd4));
    vq.push_back(mk(4'h5, 0, 1, 8'd4, {2'b11, PU},  8'd4));
    vq.push_back(mk(4'h6, 0, 0, 8'd4, {2'b00, VEC}, 8'd4));
    vq.push_back(mk(4'h6, 0, 1, 8'd4, {2'b11, VEC}, 8'd4));
    vq.push_back(mk(4'h7, 0, 0, 8'd4, {2'b01, H},   8'd4));
    vq.push_back(mk(4'h7, 1, 0, 8'd4, {2'b11, H},   8'd4));
    vq.push_back(mk(4'h8, 0, 0, 8'd3, {2'b10, H},   8'd2));
    vq.push_back(mk(4'h8, 0, 1, 8'd0, {2'b00, PO},  8'd0));
    vq.push_back(mk(4'h9, 0, 0, 8'd5, {2'b11, H},   8'd4));
    vq.push_back(mk(4'h9, 0, 0, 8'd0, {2'b00, H},   8'd0));
    vq.push_back(mk(4'hA, 0, 0, 8'd4, {2'b00, H},   8'd4));
    vq.push_back(mk(4'hA, 0, 1, 8'd4, {2'b10, PO},  8'd4));
    vq.push_back(mk(4'hB, 0, 0, 8'd4, {2'b00, H},   8'd4));
    vq.push_back(mk(4'hB, 0, 1, 8'd4, {2'b11, PO},  8'd4));
    vq.push_back(mk(4'hC, 0, 0, 8'd4, {2'b00, H},   LV));
    vq.push_back(mk(4'hD, 0, 0, 8'd4, {2'b10, H},   8'd4));
    vq.push_back(mk(4'hD, 0, 1, 8'd4, {2'b00, PO},  8'd4));
    vq.push_back(mk(4'hE, 0, 1, 8'd4, {2'b00, H},   8'd4));
    vq.push_back(mk(4'hF, 0, 1, 8'd2, {2'b00, PO},  8'd2));
    vq.push_back(mk(4'hF, 0, 0, 8'd2, {2'b10, H},   8'd1));
    vq.push_back(mk(4'hF, 0, 0, 8'd0, {2'b11, PO},  8'd0));
    vq.push_back(mk(4'hF, 0, 0, 8'd1, {2'b10, H},   8'd0));

    // ---------------- reset ----------------
    reset_n = 1'b0; instr = 4'h3; ccen_n = 1'b0; cc = 1'b1; load_val = 8'h00;
    #23;
    chk("reset_outs", {8'h0, outs}, {8'h0, 2'b00, JZH});
    chk("reset_count", {7'h0, cnt_zero, count}, {7'h0, 1'b1, 8'd0});
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("release_outs", {8'h0, outs}, {8'h0, 2'b11, H});

    // ---------------- table ----------------
    foreach (vq[k]) begin
      exp_t e;
      preload(vq[k].pre);
      @(negedge clock);
      instr = vq[k].instr; ccen_n = vq[k].ccen_n; cc = vq[k].cc; load_val = LV;
      e.name = $sformatf("vec%0d_op%h", k, vq[k].instr);
      e.o = vq[k].o; e.post = vq[k].post;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk({e.name, "_outs"}, {8'h0, outs}, {8'h0, e.o});
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      chk({e.name, "_count"}, {7'h0, cnt_zero, count},
          {7'h0, (e.post == 8'd0), e.post});
    end

    // ---------------- LDCT then RFCT ----------------
    preload(8'd3);
    @(negedge clock);
    instr = 4'h8;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ec;
      ec = 8'(3 - i);
      #1;
      chk($sformatf("rfct_cnt%0d", i), {8'h0, count}, {8'h0, ec});
      chk($sformatf("rfct_out%0d", i), {8'h0, outs},
          {8'h0, (ec != 0) ? {2'b10, H} : {2'b00, PO}});
      @(negedge clock);
    end
    @(posedge clock); #1;
    chk("rfct_stay0", {8'h0, count}, 16'h0000);

    // ---------------- reset mid-loop ----------------
    preload(8'd5);
    @(negedge clock);
    instr = 4'h9; ccen_n = 1'b0; cc = 1'b0;
    #1;
    chk("rpct_pre", {8'h0, outs}, {8'h0, 2'b11, H});
    reset_n = 1'b0;
    #1;
    chk("midrst_count", {7'h0, cnt_zero, count}, {7'h0, 1'b1, 8'd0});
    chk("midrst_outs", {8'h0, outs}, {8'h0, 2'b00, JZH});
    #1;
    reset_n = 1'b1;
    #1;
    chk("rpct_exit", {8'h0, outs}, {8'h0, 2'b00, H});
    @(posedge clock); #1;
    chk("rpct_nodec", {8'h0, count}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
